// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types: shared types for the memory responder slice.
//   lc3b_word  - 16-bit LC-3b data word
//   mem_state  - responder FSM states {IDLE, WAIT, RESP}
//   MEM_LAT_W  - width of the latency down-counter (LATENCY up to 15)
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state;

    localparam int unsigned MEM_LAT_W = 4;

endpackage

// File: rtl/mem_bytearray.sv
// -----------------------------------------------------------------------------
// mem_bytearray: 2**DEPTH_LOG2 x 16-bit store, per-byte write enable,
// combinational read. Contents have no reset.
//   clk      in   write clock
//   byte_we  in   [0] writes bits 7:0, [1] writes bits 15:8
//   addr     in   word index (shared by read and write)
//   wdata    in   write data
//   rdata    out  word at addr (combinational)
// -----------------------------------------------------------------------------
module mem_bytearray
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic [1:0]            byte_we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  lc3b_word              wdata,
    output lc3b_word              rdata
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;

    lc3b_word mem [WORDS];

    always_ff @(posedge clk) begin
        if (byte_we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (byte_we[1]) mem[addr][15:8] <= wdata[15:8];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder: fixed-latency memory model answering LC-3b style
// read/write handshakes. A request is accepted in IDLE, waits LATENCY
// cycles, and completes with a one-cycle mem_resp pulse.
//   clk              in   system clock, rising edge
//   reset            in   synchronous, active-high
//   mem_read         in   read request, held until mem_resp
//   mem_write        in   write request, held until mem_resp
//   mem_byte_enable  in   [0] bits 7:0, [1] bits 15:8 (writes)
//   mem_address      in   byte address, bit 0 ignored
//   mem_wdata        in   write data
//   mem_rdata        out  read data, non-zero only in the response cycle
//   mem_resp         out  single-cycle completion pulse
//   mem_err          out  out-of-range flag (only with MEM_RESPONDER_OOR_EN)
// Build option: define MEM_RESPONDER_OOR_EN to flag and suppress accesses
// with address bits set above DEPTH_LOG2; otherwise the store wraps.
// -----------------------------------------------------------------------------
module mem_responder
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  lc3b_word    mem_wdata,
    output lc3b_word    mem_rdata,
    output logic        mem_resp
`ifdef MEM_RESPONDER_OOR_EN
    ,
    output logic        mem_err
`endif
);

    localparam logic [MEM_LAT_W-1:0] LAT_LOAD = MEM_LAT_W'(LATENCY - 1);
    localparam logic [MEM_LAT_W-1:0] LAT_ONE  = MEM_LAT_W'(1);

    mem_state              state, state_next;
    logic [MEM_LAT_W-1:0]  cnt, cnt_next;
    logic                  accept;
    logic                  req_held;
    logic                  in_resp;

    logic [DEPTH_LOG2-1:0] lat_idx;
    lc3b_word              lat_wdata;
    logic [1:0]            lat_be;
    logic                  lat_write;
    logic                  lat_oor;

    logic [1:0]            store_we;
    lc3b_word              store_rdata;

    // Address bits outside the word index feed only the optional range check.
    logic                  unused_addr;
    assign unused_addr = ^mem_address;

    // The request that keeps a pending transaction alive is the one that
    // was accepted; the other request line is irrelevant until IDLE.
    assign req_held = lat_write ? mem_write : mem_read;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // Exactly one request line high; both high is ignored.
                if (mem_read ^ mem_write) begin
                    accept   = 1'b1;
                    cnt_next = LAT_LOAD;
                    if (LATENCY == 1) state_next = RESP;
                    else              state_next = WAIT;
                end
            end
            WAIT: begin
                if (!req_held) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                    if (cnt == LAT_ONE) state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_idx   <= mem_address[DEPTH_LOG2:1];
            lat_wdata <= mem_wdata;
            lat_be    <= mem_byte_enable;
            lat_write <= mem_write;
        end
    end

`ifdef MEM_RESPONDER_OOR_EN
    always_ff @(posedge clk) begin
        if (accept) lat_oor <= |(mem_address >> (DEPTH_LOG2 + 1));
    end
    assign mem_err = in_resp && lat_oor;
`else
    assign lat_oor = 1'b0;
`endif

    // Gating with reset keeps outputs quiet and blocks the write when reset
    // lands while the registered state is still RESP.
    assign in_resp   = (state == RESP) && !reset;
    assign mem_resp  = in_resp;
    assign store_we  = (in_resp && lat_write && !lat_oor) ? lat_be : 2'b00;
    assign mem_rdata = (in_resp && !lat_write && !lat_oor) ? store_rdata : '0;

    mem_bytearray #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk     (clk),
        .byte_we (store_we),
        .addr    (lat_idx),
        .wdata   (lat_wdata),
        .rdata   (store_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder: directed bench for mem_responder. Two instances share
// the clock: dut2 (LATENCY=2) and dut4 (LATENCY=4), both DEPTH_LOG2=8.
// Expected responses are queued before each transaction is driven and
// compared when the response pulse arrives. Honours MEM_RESPONDER_OOR_EN.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import lc3b_types::*;

    typedef struct {
        logic [15:0] rdata;
        int          lat;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;

    logic        rst2 = 1'b1, rd2 = 1'b0, wr2 = 1'b0;
    logic [1:0]  be2 = '0;
    logic [15:0] addr2 = '0, wd2 = '0;
    lc3b_word    rdata2;
    logic        resp2;

    logic        rst4 = 1'b1, rd4 = 1'b0, wr4 = 1'b0;
    logic [1:0]  be4 = '0;
    logic [15:0] addr4 = '0, wd4 = '0;
    lc3b_word    rdata4;
    logic        resp4;

`ifdef MEM_RESPONDER_OOR_EN
    logic        err2, err4;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2), .DEPTH_LOG2(8)) dut2 (
        .clk(clk), .reset(rst2), .mem_read(rd2), .mem_write(wr2),
        .mem_byte_enable(be2), .mem_address(addr2), .mem_wdata(wd2),
        .mem_rdata(rdata2), .mem_resp(resp2)
`ifdef MEM_RESPONDER_OOR_EN
        , .mem_err(err2)
`endif
    );

    mem_responder #(.LATENCY(4), .DEPTH_LOG2(8)) dut4 (
        .clk(clk), .reset(rst4), .mem_read(rd4), .mem_write(wr4),
        .mem_byte_enable(be4), .mem_address(addr4), .mem_wdata(wd4),
        .mem_rdata(rdata4), .mem_resp(resp4)
`ifdef MEM_RESPONDER_OOR_EN
        , .mem_err(err4)
`endif
    );

    task automatic drive(input bit use4, input logic r, input logic w,
                         input logic [1:0] be, input logic [15:0] a, input logic [15:0] d);
        if (use4) begin rd4 = r; wr4 = w; be4 = be; addr4 = a; wd4 = d; end
        else      begin rd2 = r; wr2 = w; be2 = be; addr2 = a; wd2 = d; end
    endtask

    // Drives one request and holds it until mem_resp (or a 40-cycle bound,
    // reported as lat=-1). lat counts sampled cycles after acceptance.
    // With scramble set, address/data/byte-enables are randomised after
    // acceptance while the request line stays high.
    task automatic run_txn(input bit use4, input bit wr, input logic [15:0] a,
                           input logic [1:0] be, input logic [15:0] d, input bit scramble,
                           output int lat, output logic [15:0] rd, output logic er);
        logic r;
        @(negedge clk);
        drive(use4, !wr, wr, be, a, d);
        lat = -1; rd = '0; er = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            r = use4 ? resp4 : resp2;
            if (r) begin
                lat = k;
                rd  = use4 ? rdata4 : rdata2;
`ifdef MEM_RESPONDER_OOR_EN
                er  = use4 ? err4 : err2;
`endif
            end else if (scramble) begin
                drive(use4, !wr, wr, 2'($urandom), 16'($urandom), 16'($urandom));
            end
        end
        drive(use4, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst4 = 1'b1;
        drive(0, 1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000);
        drive(1, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hFFFF);
        repeat (3) @(negedge clk);
        checks++; if (resp2 !== 1'b0) begin failures++; $display("FAIL reset_resp2 got=%b exp=0", resp2); end
        checks++; if (rdata2 !== 16'h0000) begin failures++; $display("FAIL reset_rdata2 got=%h exp=0000", rdata2); end
        checks++; if (dut2.state !== IDLE) begin failures++; $display("FAIL reset_state2 got=%0d exp=%0d", dut2.state, IDLE); end
        checks++; if (dut2.cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt2 got=%0d exp=0", dut2.cnt); end
        checks++; if (resp4 !== 1'b0) begin failures++; $display("FAIL reset_resp4 got=%b exp=0", resp4); end
        checks++; if (dut4.state !== IDLE) begin failures++; $display("FAIL reset_state4 got=%0d exp=%0d", dut4.state, IDLE); end
`ifdef MEM_RESPONDER_OOR_EN
        checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL reset_err2 got=%b exp=0", err2); end
`endif
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        rst2 = 1'b0; rst4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e; int lat; logic [15:0] rd; logic er;
        sb.push_back('{rdata: 16'h0000, lat: 2, err: 1'b0});
        run_txn(0, 1'b1, 16'h0010, 2'b11, 16'hBEEF, 1'b1, lat, rd, er);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL basic_wr_lat got=%0d exp=%0d", lat, e.lat); end
        sb.push_back('{rdata: 16'hBEEF, lat: 2, err: 1'b0});
        run_txn(0, 1'b0, 16'h0010, 2'b00, 16'h0000, 1'b0, lat, rd, er);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL basic_rd_lat got=%0d exp=%0d", lat, e.lat); end
        checks++; if (rd !== e.rdata) begin failures++; $display("FAIL basic_rd_data got=%h exp=%h", rd, e.rdata); end
        @(negedge clk);
        checks++; if (rdata2 !== 16'h0000) begin failures++; $display("FAIL basic_idle_rdata got=%h exp=0000", rdata2); end
    endtask

    task automatic test_partial();
        exp_t e; int lat; logic [15:0] rd; logic er;
        bit          st_wr [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  st_be [7] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
        logic [15:0] st_d  [7] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h0000, 16'h5600, 16'h0000};
        logic [15:0] st_x  [7] = '{16'h0000, 16'h0000, 16'h12CD, 16'h0000, 16'h12CD, 16'h0000, 16'h56CD};
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{rdata: st_x[i], lat: 2, err: 1'b0});
            run_txn(0, st_wr[i], 16'h0030, st_be[i], st_d[i], 1'b0, lat, rd, er);
            e = sb.pop_front();
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL partial_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            if (!st_wr[i]) begin
                checks++; if (rd !== e.rdata) begin failures++; $display("FAIL partial_data[%0d] got=%h exp=%h", i, rd, e.rdata); end
            end
        end
    endtask

    task automatic test_drop();
        exp_t e; int lat; logic [15:0] rd; logic er; int pulses;
        sb.push_back('{rdata: 16'h0000, lat: 4, err: 1'b0});
        run_txn(1, 1'b1, 16'h0020, 2'b11, 16'h1111, 1'b0, lat, rd, er);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL drop_prewr_lat got=%0d exp=%0d", lat, e.lat); end
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 2'b11, 16'h0020, 16'h5555);
        @(negedge clk);
        checks++; if (dut4.state !== WAIT) begin failures++; $display("FAIL drop_in_wait got=%0d exp=%0d", dut4.state, WAIT); end
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp4) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL drop_no_resp got=%0d exp=0", pulses); end
        checks++; if (dut4.state !== IDLE) begin failures++; $display("FAIL drop_state got=%0d exp=%0d", dut4.state, IDLE); end
        sb.push_back('{rdata: 16'h1111, lat: 4, err: 1'b0});
        run_txn(1, 1'b0, 16'h0020, 2'b00, 16'h0000, 1'b0, lat, rd, er);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin failures++; $display("FAIL drop_readback got=%h exp=%h", rd, e.rdata); end
    endtask

    task automatic test_reset_in_resp();
        exp_t e; int lat; logic [15:0] rd; logic er;
        sb.push_back('{rdata: 16'h0000, lat: 2, err: 1'b0});
        run_txn(0, 1'b1, 16'h0040, 2'b11, 16'h3333, 1'b0, lat, rd, er);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL rstresp_prewr_lat got=%0d exp=%0d", lat, e.lat); end
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'h7777);
        repeat (2) @(negedge clk);
        checks++; if (dut2.state !== RESP) begin failures++; $display("FAIL rstresp_in_resp got=%0d exp=%0d", dut2.state, RESP); end
        rst2 = 1'b1;
        #1;
        checks++; if (resp2 !== 1'b0) begin failures++; $display("FAIL rstresp_resp got=%b exp=0", resp2); end
        @(negedge clk);
        checks++; if (dut2.state !== IDLE) begin failures++; $display("FAIL rstresp_state got=%0d exp=%0d", dut2.state, IDLE); end
        checks++; if (resp2 !== 1'b0) begin failures++; $display("FAIL rstresp_resp_after got=%b exp=0", resp2); end
        rst2 = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        sb.push_back('{rdata: 16'h3333, lat: 2, err: 1'b0});
        run_txn(0, 1'b0, 16'h0040, 2'b00, 16'h0000, 1'b0, lat, rd, er);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin failures++; $display("FAIL rstresp_nowrite got=%h exp=%h", rd, e.rdata); end
        sb.push_back('{rdata: 16'hBEEF, lat: 2, err: 1'b0});
        run_txn(0, 1'b0, 16'h0010, 2'b00, 16'h0000, 1'b0, lat, rd, er);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin failures++; $display("FAIL rstresp_intact got=%h exp=%h", rd, e.rdata); end
    endtask

    task automatic test_both_high();
        exp_t e; int lat; logic [15:0] rd; logic er;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b11, 16'h0010, 16'h0000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (resp2 !== 1'b0) begin failures++; $display("FAIL both_resp[%0d] got=%b exp=0", k, resp2); end
            checks++; if (dut2.state !== IDLE) begin failures++; $display("FAIL both_state[%0d] got=%0d exp=%0d", k, dut2.state, IDLE); end
        end
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        sb.push_back('{rdata: 16'hBEEF, lat: 2, err: 1'b0});
        run_txn(0, 1'b0, 16'h0010, 2'b00, 16'h0000, 1'b0, lat, rd, er);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin failures++; $display("FAIL both_nowrite got=%h exp=%h", rd, e.rdata); end
    endtask

    task automatic test_back_to_back();
        exp_t e; bit want;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            want = (k % 3 == 2);
            if (want) sb.push_back('{rdata: 16'hBEEF, lat: 2, err: 1'b0});
            checks++; if (resp2 !== want) begin failures++; $display("FAIL b2b_resp[%0d] got=%b exp=%b", k, resp2, want); end
            if (resp2 === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (rdata2 !== e.rdata) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, rdata2, e.rdata); end
            end
        end
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d exp=0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_oor();
        exp_t e; int lat; logic [15:0] rd; logic er;
        logic [15:0] t_a [4] = '{16'h0000, 16'h0400, 16'h0000, 16'h0400};
        bit          t_w [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] t_d [4] = '{16'hCAFE, 16'h9999, 16'h0000, 16'h0000};
`ifdef MEM_RESPONDER_OOR_EN
        logic [15:0] t_x [4] = '{16'h0000, 16'h0000, 16'hCAFE, 16'h0000};
        logic        t_e [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        logic [15:0] t_x [4] = '{16'h0000, 16'h0000, 16'h9999, 16'h9999};
        logic        t_e [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{rdata: t_x[i], lat: 2, err: t_e[i]});
            run_txn(0, t_w[i], t_a[i], 2'b11, t_d[i], 1'b0, lat, rd, er);
            e = sb.pop_front();
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL oor_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
            if (!t_w[i]) begin
                checks++; if (rd !== e.rdata) begin failures++; $display("FAIL oor_data[%0d] got=%h exp=%h", i, rd, e.rdata); end
            end
`ifdef MEM_RESPONDER_OOR_EN
            checks++; if (er !== e.err) begin failures++; $display("FAIL oor_err[%0d] got=%b exp=%b", i, er, e.err); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_drop();
        test_reset_in_resp();
        test_both_high();
        test_back_to_back();
        test_oor();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
